// File: rtl/poly_redun_to_canon.sv
// Normaliser: folds redundant polynomial coefficients into one integer by
// word-serial carry propagation, then reduces it below MODULUS by shifted subtraction.
module poly_redun_to_canon #(
   parameter int WORD_BITS       = 16,
   parameter int NUM_WORDS       = 8,
   parameter int REDUN_WORD_BITS = 1,
   parameter int I_WORD          = NUM_WORDS + 1,
   parameter int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
   parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF6
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_val,
   output logic                             o_rdy,
   input  logic [I_WORD*COEF_BITS-1:0]      i_dat,
   output logic                             o_val,
   input  logic                             i_rdy,
   output logic [I_WORD*COEF_BITS-1:0]      o_dat,
   output logic [WORD_BITS*NUM_WORDS-1:0]   o_int
);

   // state    | meaning
   // S_IDLE   | ready, waiting for i_val
   // S_CARRY  | propagating carry, one coefficient per cycle
   // S_REDUCE | conditional subtract of MODULUS<<k, k = SHIFT..0
   // S_DONE   | result presented, waiting for i_rdy

   localparam int MB = WORD_BITS * NUM_WORDS;

   function automatic int f_bitlen(input logic [MB-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MB; i++)
         if (v[i]) n = i + 1;
      return n;
   endfunction

   localparam int W_IN    = WORD_BITS * (I_WORD - 1) + COEF_BITS + 1;
   localparam int MOD_LEN = f_bitlen(MODULUS);
   localparam int SHIFT   = W_IN - MOD_LEN;
   localparam int JW      = $clog2(I_WORD);
   localparam int KW      = $clog2(SHIFT + 1);
   localparam int CW      = 3;

   typedef enum logic [1:0] {S_IDLE, S_CARRY, S_REDUCE, S_DONE} state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [I_WORD*COEF_BITS-1:0] r_din;
   logic [W_IN-1:0]           r_v;
   logic [CW-1:0]             r_carry;
   logic [JW-1:0]             r_j;
   logic [KW-1:0]             r_k;
   logic                      r_oval;
   logic [MB-1:0]             r_res;

   logic [COEF_BITS-1:0]      w_coef;
   logic [COEF_BITS:0]        w_sum;
   logic [W_IN-1:0]           w_mod_sh;

   assign w_coef   = r_din[r_j*COEF_BITS +: COEF_BITS];
   assign w_sum    = {1'b0, w_coef} + (COEF_BITS+1)'(r_carry);
   assign w_mod_sh = {{(W_IN-MB){1'b0}}, MODULUS} << r_k;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_val)                    w_next = S_CARRY;
         S_CARRY:  if (r_j == JW'(I_WORD - 1))   w_next = S_REDUCE;
         S_REDUCE: if (r_k == '0)                w_next = S_DONE;
         S_DONE:   if (r_oval && i_rdy)          w_next = S_IDLE;
         default:                                w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_din   <= '0;
         r_v     <= '0;
         r_carry <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_oval  <= 1'b0;
         r_res   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_val) begin
                  r_din   <= i_dat;
                  r_v     <= '0;
                  r_carry <= '0;
                  r_j     <= '0;
               end
            end
            S_CARRY: begin
               // The last coefficient keeps its full sum as the top of V.
               if (r_j == JW'(I_WORD - 1)) begin
                  r_v[W_IN-1 -: COEF_BITS+1] <= w_sum;
                  r_k                        <= KW'(SHIFT);
               end else begin
                  r_v[r_j*WORD_BITS +: WORD_BITS] <= w_sum[WORD_BITS-1:0];
                  r_carry                         <= CW'(w_sum >> WORD_BITS);
                  r_j                             <= r_j + JW'(1);
               end
            end
            S_REDUCE: begin
               if (r_v >= w_mod_sh) r_v <= r_v - w_mod_sh;
               if (r_k != '0)       r_k <= r_k - KW'(1);
            end
            S_DONE: begin
               if (!r_oval) begin
                  r_oval <= 1'b1;
                  r_res  <= r_v[MB-1:0];
               end else if (i_rdy) begin
                  r_oval <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_rdy = (r_state == S_IDLE);
   assign o_val = r_oval;
   assign o_int = r_res;

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
      assign o_dat[g*COEF_BITS +: COEF_BITS] = {{REDUN_WORD_BITS{1'b0}}, r_res[g*WORD_BITS +: WORD_BITS]};
   end
   assign o_dat[I_WORD*COEF_BITS-1 : NUM_WORDS*COEF_BITS] = '0;

endmodule
